// File: rtl/fetch_unit_if.sv
// Memory, instruction and redirect signals of the byte-prefetch fetch front end.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [7:0]        inst_op;
  logic [7:0]        inst_ext;
  logic              inst_long;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] inst_next_pc;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output inst_valid, inst_op, inst_ext, inst_long, inst_pc, inst_next_pc,
    input  inst_ready, redir_valid, redir_pc
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  inst_valid, inst_op, inst_ext, inst_long, inst_pc, inst_next_pc,
    output inst_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte prefetch buffer that assembles 1/2-byte instructions, with redirect/flush.
// Define FETCH_PERF_EN to add the stall_cnt performance counter output.
module fetch_unit #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = PTR_W + 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  entry_t            buf_q [DEPTH];
  entry_t            buf_n [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
  logic [CNT_W-1:0]  count_q, count_n, pend_q, pend_n, drop_q, drop_n, pop_len;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n, resp_pc_q, resp_pc_n;
  logic              issue, pop, push, mem_req_n;
  entry_t            head0, head1, wr_entry;
  logic              head_long, valid_n;

  logic              mem_req_q, inst_valid_q, inst_long_q;
  logic [7:0]        inst_op_q, inst_ext_q;
  logic [ADDR_W-1:0] inst_pc_q, inst_next_pc_q;

  // pend counts every outstanding read; drop is the stale subset still to arrive
  always_comb begin
    issue    = mem_req_q && bus.mem_gnt;
    pop      = inst_valid_q && bus.inst_ready;
    pop_len  = pop ? (inst_long_q ? CNT_W'(2) : CNT_W'(1)) : '0;
    push     = bus.mem_rvalid && (drop_q == '0) && !bus.redir_valid;
    wr_entry.addr = resp_pc_q;
    wr_entry.data = bus.mem_rdata;

    pend_n     = pend_q + CNT_W'(issue) - CNT_W'(bus.mem_rvalid);
    drop_n     = drop_q - CNT_W'(bus.mem_rvalid && (drop_q != '0));
    fetch_pc_n = fetch_pc_q + ADDR_W'(issue);
    resp_pc_n  = resp_pc_q + ADDR_W'(push);
    wr_ptr_n   = wr_ptr_q + PTR_W'(push);
    rd_ptr_n   = rd_ptr_q + PTR_W'(pop_len);
    count_n    = count_q + CNT_W'(push) - pop_len;

    if (bus.redir_valid) begin
      fetch_pc_n = bus.redir_pc;
      resp_pc_n  = bus.redir_pc;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      count_n    = '0;
      drop_n     = pend_n;
    end

    mem_req_n = (SUM_W'(count_n) + SUM_W'(pend_n)) < SUM_W'(DEPTH);

    // Look ahead at the post-edge buffer so the instruction outputs can be registered
    buf_n = buf_q;
    if (push) buf_n[wr_ptr_q] = wr_entry;
    head0     = buf_n[rd_ptr_n];
    head1     = buf_n[rd_ptr_n + PTR_W'(1)];
    head_long = !head0.data[7] || (head0.data[7:5] == 3'b110);
    valid_n   = (count_n >= CNT_W'(2)) || ((count_n == CNT_W'(1)) && !head_long);
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      pend_q         <= '0;
      drop_q         <= '0;
      fetch_pc_q     <= '0;
      resp_pc_q      <= '0;
      mem_req_q      <= 1'b0;
      inst_valid_q   <= 1'b0;
      inst_long_q    <= 1'b0;
      inst_op_q      <= '0;
      inst_ext_q     <= '0;
      inst_pc_q      <= '0;
      inst_next_pc_q <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_n;
      wr_ptr_q       <= wr_ptr_n;
      count_q        <= count_n;
      pend_q         <= pend_n;
      drop_q         <= drop_n;
      fetch_pc_q     <= fetch_pc_n;
      resp_pc_q      <= resp_pc_n;
      mem_req_q      <= mem_req_n;
      inst_valid_q   <= valid_n;
      inst_long_q    <= valid_n && head_long;
      inst_op_q      <= valid_n ? head0.data : 8'h00;
      inst_ext_q     <= (valid_n && head_long) ? head1.data : 8'h00;
      inst_pc_q      <= valid_n ? head0.addr : '0;
      inst_next_pc_q <= valid_n ? head0.addr + (head_long ? ADDR_W'(2) : ADDR_W'(1)) : '0;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = fetch_pc_q;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.inst_long    = inst_long_q;
  assign bus.inst_op      = inst_op_q;
  assign bus.inst_ext     = inst_ext_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.inst_next_pc = inst_next_pc_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q;

  // Cycles where the controller was waiting on an empty/incomplete buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (bus.redir_valid) begin
      stall_q <= '0;
    end else if (bus.inst_ready && !inst_valid_q && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a decode-from-memory reference.
module tb_fetch_unit;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MEM_SZ = 1 << ADDR_W;

  typedef struct packed {
    logic [7:0]        op;
    logic [7:0]        ext;
    logic              lng;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
  } exp_t;

  typedef struct packed {
    int unsigned due;
    logic [7:0]  data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  logic [7:0]  mem [MEM_SZ];
  exp_t        exp_q [$];
  rsp_t        rsp_q [$];
  int unsigned gen_pc = 0;
  int          lat = 1;
  int          gnt_mode = 1;
  bit          rnd_ready = 1'b0;
  int unsigned edge_n = 0;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the instruction stream is a plain decode of memory starting at a pc
  function automatic exp_t decode(input int unsigned pc);
    exp_t e;
    e.op  = mem[pc % MEM_SZ];
    e.lng = !e.op[7] || (e.op[7:5] == 3'b110);
    e.ext = e.lng ? mem[(pc + 1) % MEM_SZ] : 8'h00;
    e.pc  = ADDR_W'(pc % MEM_SZ);
    e.npc = ADDR_W'((pc + (e.lng ? 2 : 1)) % MEM_SZ);
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] op, input logic [7:0] ext, input logic lng,
                              input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] npc);
    exp_t e;
    e.op = op; e.ext = ext; e.lng = lng; e.pc = pc; e.npc = npc;
    return e;
  endfunction

  task automatic topup();
    exp_t e;
    while (exp_q.size() < 32) begin
      e = decode(gen_pc);
      exp_q.push_back(e);
      gen_pc = 32'(e.npc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    topup();
    if (rnd_ready) bus.inst_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    int target;
    int k;
    target = pops + n;
    k = 0;
    while (pops < target && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (pops < target) begin
      bad++;
      $display("FAIL %s: delivered=%0d required=%0d within %0d cycles", name, pops - (target - n), n, budget);
    end
  endtask

  // Caller is just after a rising edge; the redirect is sampled at the next edge
  task automatic redirect(input logic [ADDR_W-1:0] pc, input bit use_dir, input exp_t dir);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = pc;
    @(posedge clk); #1;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = ADDR_W'($urandom);
    exp_q.delete();
    if (use_dir) begin
      exp_q.push_back(dir);
      gen_pc = 32'(dir.npc);
    end else begin
      gen_pc = 32'(pc);
    end
    topup();
    if (rnd_ready) bus.inst_ready = ($urandom_range(0, 99) < 70);
  endtask

  // Memory: in-order responses, fixed latency per phase, grant policy per phase
  initial begin
    bit                fire;
    logic [ADDR_W-1:0] fa;
    rsp_t              r;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      fire = bus.mem_req && bus.mem_gnt && rst;
      fa   = bus.mem_addr;
      @(posedge clk); #1;
      edge_n++;
      if (!rst) rsp_q.delete();
      else if (fire) begin
        r.due  = edge_n + 32'(lat);
        r.data = mem[fa];
        rsp_q.push_back(r);
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'($urandom);
      if (rst && rsp_q.size() != 0 && rsp_q[0].due <= edge_n + 1) begin
        r = rsp_q.pop_front();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = r.data;
      end
      case (gnt_mode)
        0:       bus.mem_gnt = 1'($urandom_range(0, 1));
        1:       bus.mem_gnt = 1'b1;
        default: bus.mem_gnt = 1'b0;
      endcase
    end
  end

  // Monitor: pops an expected instruction on every accepted handshake
  initial begin
    exp_t              e;
    exp_t              got;
    bit                hold = 1'b0;
    logic [ADDR_W-1:0] hold_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (bus.inst_valid && bus.inst_ready) begin
          pops++;
          total++;
          got = mk(bus.inst_op, bus.inst_ext, bus.inst_long, bus.inst_pc, bus.inst_next_pc);
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL inst_extra: got op=%h pc=%h, required no instruction", got.op, got.pc);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL inst: got op=%h ext=%h long=%b pc=%h npc=%h required op=%h ext=%h long=%b pc=%h npc=%h",
                       got.op, got.ext, got.lng, got.pc, got.npc, e.op, e.ext, e.lng, e.pc, e.npc);
            end
          end
        end
        if (hold) begin
          total++;
          if (!(bus.mem_req && bus.mem_addr == hold_addr)) begin
            bad++;
            $display("FAIL req_hold: got req=%b addr=%h required req=1 addr=%h", bus.mem_req, bus.mem_addr, hold_addr);
          end
        end
        hold      = bus.mem_req && !bus.mem_gnt && !bus.redir_valid;
        hold_addr = bus.mem_addr;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   p0;
    exp_t none;
    none = '0;
    for (int i = 0; i < int'(MEM_SZ); i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE5;
    mem[1] = 8'h12;
    bus.inst_ready  = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;

    repeat (3) @(negedge clk);
    chk("rst_mem_req",   32'(bus.mem_req), 0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 0);
    chk("rst_valid",     32'(bus.inst_valid), 0);
    chk("rst_op",        32'(bus.inst_op), 0);
    chk("rst_ext",       32'(bus.inst_ext), 0);
    chk("rst_long",      32'(bus.inst_long), 0);
    chk("rst_pc",        32'(bus.inst_pc), 0);
    chk("rst_next_pc",   32'(bus.inst_next_pc), 0);

    exp_q.push_back(mk(8'hE5, 8'h00, 1'b0, 13'd0, 13'd1));
    exp_q.push_back(mk(8'h12, mem[2], 1'b1, 13'd1, 13'd3));
    gen_pc = 3;
    topup();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_req",  32'(bus.mem_req), 1);
    chk("first_addr", 32'(bus.mem_addr), 0);
    wait_pops("startup", 6, 60);

    // Backpressure: buffer and outstanding reads fill, then requests stop
    bus.inst_ready = 1'b0;
    cycles(10);
    @(negedge clk);
    chk("full_req_low", 32'(bus.mem_req), 0);
    @(posedge clk); #1;
    bus.inst_ready = 1'b1;
    wait_pops("drain_after_full", 8, 60);

    // Long instruction straddling the top of the address space
    mem[0]        = 8'hAA;
    mem[MEM_SZ-1] = 8'h1F;
    redirect(ADDR_W'(MEM_SZ - 1), 1'b1, mk(8'h1F, 8'hAA, 1'b1, ADDR_W'(MEM_SZ - 1), 13'd1));
    wait_pops("wrap", 4, 60);

    // Latency 3: redirect while three reads are outstanding
    lat = 3;
    redirect(13'h0200, 1'b0, none);
    cycles(3);
    redirect(13'h0100, 1'b0, none);
    wait_pops("stale_drop", 6, 100);

    // Redirect in the same cycle as an accepted instruction
    lat = 1;
    cycles(4);
    k = 0;
    while (!bus.inst_valid && k < 50) begin
      tick();
      k++;
    end
    chk("coincide_valid", 32'(bus.inst_valid), 1);
    p0 = pops;
    redirect(13'h0400, 1'b0, none);
    chk("coincide_pop_once", 32'(pops - p0), 1);
    wait_pops("after_coincide", 5, 60);

`ifdef FETCH_PERF_EN
    gnt_mode = 2;
    redirect(13'h0300, 1'b0, none);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt", 32'(stall_cnt), 5);
    @(posedge clk); #1;
    gnt_mode = 1;
    wait_pops("after_stall", 3, 60);
`endif

    // Randomized grants, readiness, latency and redirects
    rnd_ready = 1'b1;
    gnt_mode  = 0;
    for (int seg = 0; seg < 4; seg++) begin
      lat = $urandom_range(1, 3);
      for (int c = 0; c < 300; c++) begin
        tick();
        if ($urandom_range(0, 99) < 3) redirect(ADDR_W'($urandom), 1'b0, none);
      end
    end

    rnd_ready = 1'b0;
    gnt_mode  = 1;
    bus.inst_ready = 1'b1;
    wait_pops("final_drain", 20, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
